dec_cfg_master: RTL

DEC_CFG_MASTER -- requirements
Module: dec_cfg_master

---
 rtl/dec_cfg_master_pkg.sv | 21 ++
 rtl/dec_cfg_master_if.sv | 29 ++
 rtl/dec_cfg_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dec_cfg_master_pkg.sv
// Shared types and constants for the decimator configuration master.
// Holds the sequencer state encoding and the control/RAM address constants.
package dec_pkg;

    localparam int   RAM_AW       = 4;
    localparam logic CTL_RUN_ADDR = 1'b0;
    localparam logic CTL_DIV_ADDR = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        STOP,
        LOAD,
        DIV,
        RUN,
        RB0,
        RB1,
        DONE,
        HALT
    } state_t;

endpackage

// File: rtl/dec_cfg_master_if.sv
// Control-slave and period-RAM bus driven by the configuration master.
// Both slaves are zero-wait: every strobe completes in its own cycle.
interface dec_cfg_master_if #(
    parameter int M = 32
);
    import dec_pkg::*;

    logic              ctl_wr;
    logic              ctl_rd;
    logic              ctl_addr;
    logic [M-1:0]      ctl_wrdata;
    logic [M-1:0]      ctl_rddata;
    logic              ram_wr;
    logic [RAM_AW-1:0] ram_addr;
    logic [M-1:0]      ram_wrdata;

    modport master (
        output ctl_wr, ctl_rd, ctl_addr, ctl_wrdata,
        output ram_wr, ram_addr, ram_wrdata,
        input  ctl_rddata
    );

    modport slave (
        input  ctl_wr, ctl_rd, ctl_addr, ctl_wrdata,
        input  ram_wr, ram_addr, ram_wrdata,
        output ctl_rddata
    );

endinterface

// File: rtl/dec_cfg_master.sv
// Configuration master: stops the semaphore, loads the period RAM, programs the
// divider, restarts, and reads both control registers back to verify them.
module dec_cfg_master
    import dec_pkg::*;
#(
    parameter int M      = 32,
    parameter int NWORDS = 16
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    start,
    input  logic                    halt,
    input  logic [M-1:0]            base_period,
    input  logic [1:0]              div_sel,
    dec_cfg_master_if.master        bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam logic [RAM_AW-1:0] LAST_ADDR = RAM_AW'(NWORDS - 1);

    state_t            state;
    logic [RAM_AW-1:0] cnt;
    logic [M-1:0]      base_q;
    logic [1:0]        div_q;

    logic              ctl_wr_q;
    logic              ctl_rd_q;
    logic              ctl_addr_q;
    logic [M-1:0]      ctl_wrdata_q;
    logic              ram_wr_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [M-1:0]      ram_wrdata_q;

    // Only the two low readback bits carry meaning; the rest are don't-care.
    logic unused_rddata;
    assign unused_rddata = ^bus.ctl_rddata[M-1:2];

    // Word i doubles the base every four entries and adds a small offset.
    function automatic logic [M-1:0] ram_word(input logic [M-1:0] b,
                                              input logic [RAM_AW-1:0] i);
        return (b << i[3:2]) + M'(i[1:0]);
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            // NOTE: the latched base/div and the word counter are plain registers, so
            // they are cleared here along with the state; nothing resumes after reset.
            state        <= IDLE;
            cnt          <= '0;
            base_q       <= '0;
            div_q        <= '0;
            ctl_wr_q     <= 1'b0;
            ctl_rd_q     <= 1'b0;
            ctl_addr_q   <= CTL_RUN_ADDR;
            ctl_wrdata_q <= '0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // NOTE: strobes, addresses and data default to zero every cycle and are
            // only raised for the state being entered, so all bus outputs are registered.
            ctl_wr_q     <= 1'b0;
            ctl_rd_q     <= 1'b0;
            ctl_addr_q   <= CTL_RUN_ADDR;
            ctl_wrdata_q <= '0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;

            if (start && (state == IDLE || state == DONE)) begin
                base_q   <= base_period;
                div_q    <= div_sel;
                done     <= 1'b0;
                error    <= 1'b0;
                busy     <= 1'b1;
                state    <= STOP;
                ctl_wr_q <= 1'b1;
            end else begin
                case (state)
                    STOP: begin
                        state        <= LOAD;
                        cnt          <= '0;
                        ram_wr_q     <= 1'b1;
                        ram_wrdata_q <= ram_word(base_q, '0);
                    end
                    LOAD: begin
                        if (cnt == LAST_ADDR) begin
                            state        <= DIV;
                            ctl_wr_q     <= 1'b1;
                            ctl_addr_q   <= CTL_DIV_ADDR;
                            ctl_wrdata_q <= M'(div_q);
                        end else begin
                            cnt          <= cnt + 1'b1;
                            ram_wr_q     <= 1'b1;
                            ram_addr_q   <= cnt + 1'b1;
                            ram_wrdata_q <= ram_word(base_q, cnt + 1'b1);
                        end
                    end
                    DIV: begin
                        state        <= RUN;
                        ctl_wr_q     <= 1'b1;
                        ctl_wrdata_q <= M'(1);
                    end
                    RUN: begin
                        state    <= RB0;
                        ctl_rd_q <= 1'b1;
                    end
                    RB0: begin
                        if (!bus.ctl_rddata[0]) error <= 1'b1;
                        state      <= RB1;
                        ctl_rd_q   <= 1'b1;
                        ctl_addr_q <= CTL_DIV_ADDR;
                    end
                    RB1: begin
                        if (bus.ctl_rddata[1:0] != div_q) error <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    DONE: begin
                        if (halt) begin
                            state    <= HALT;
                            busy     <= 1'b1;
                            ctl_wr_q <= 1'b1;
                        end
                    end
                    HALT: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                    IDLE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ctl_wr     = ctl_wr_q;
    assign bus.ctl_rd     = ctl_rd_q;
    assign bus.ctl_addr   = ctl_addr_q;
    assign bus.ctl_wrdata = ctl_wrdata_q;
    assign bus.ram_wr     = ram_wr_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wrdata = ram_wrdata_q;

endmodule
